// File: rtl/sb_rx_header_router.sv
// Sideband receive header router: frames 64-bit deserialized words into header/payload,
// checks CP/DP parity and routes RDI and LTSM messages to their decoders, counting drops.
module sb_rx_header_router #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_deser_data,
    input  logic        i_deser_valid,
    output logic        o_rdi_start_en,
    output logic [63:0] o_rdi_header,
    output logic        o_ltsm_start_en,
    output logic [63:0] o_ltsm_header,
    output logic [63:0] o_ltsm_data,
    output logic        o_ltsm_has_data,
    output logic        o_parity_err,
    output logic        o_timeout_err,
    output logic [7:0]  o_drop_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_WAIT   = 1'b1;
    localparam logic [4:0] OP_NODATA = 5'b10010;
    localparam logic [4:0] OP_DATA   = 5'b11011;
    localparam logic [2:0] SRC_RDI   = 3'b001;
    localparam logic [2:0] SRC_LTSM  = 3'b010;
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);

    function automatic logic cp_ok(input logic [63:0] hdr);
        return hdr[62] == (^hdr[61:0]);
    endfunction

    function automatic logic dp_ok(input logic dp, input logic [63:0] payload);
        return dp == (^payload);
    endfunction

    logic [0:0]  state_r;
    logic [0:0]  state_s;
    logic [7:0]  timer_r;
    logic [7:0]  timer_s;
    logic [63:0] pend_hdr_r;
    logic [63:0] pend_hdr_s;

    logic        rdi_start_r;
    logic [63:0] rdi_hdr_r;
    logic        ltsm_start_r;
    logic [63:0] ltsm_hdr_r;
    logic [63:0] ltsm_data_r;
    logic        ltsm_has_data_r;
    logic        par_err_r;
    logic        tmo_err_r;
    logic [7:0]  drop_cnt_r;

    logic        emit_rdi_s;
    logic        emit_ltsm_s;
    logic        emit_has_data_s;
    logic [63:0] emit_hdr_s;
    logic [63:0] emit_data_s;
    logic        par_err_s;
    logic        tmo_err_s;
    logic        drop_s;

    logic [4:0]  opcode_s;
    logic [2:0]  srcid_s;

    assign opcode_s = i_deser_data[4:0];
    assign srcid_s  = i_deser_data[31:29];

    // Next-state, classification and parity checking for the current word.
    always_comb begin
        state_s         = state_r;
        timer_s         = timer_r;
        pend_hdr_s      = pend_hdr_r;
        emit_rdi_s      = 1'b0;
        emit_ltsm_s     = 1'b0;
        emit_has_data_s = 1'b0;
        emit_hdr_s      = i_deser_data;
        emit_data_s     = 64'h0;
        par_err_s       = 1'b0;
        tmo_err_s       = 1'b0;
        drop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_deser_valid) begin
                    case (opcode_s)
                        OP_NODATA: begin
                            if ((srcid_s == SRC_RDI) || (srcid_s == SRC_LTSM)) begin
                                if (cp_ok(i_deser_data) && !i_deser_data[63]) begin
                                    emit_rdi_s  = (srcid_s == SRC_RDI);
                                    emit_ltsm_s = (srcid_s == SRC_LTSM);
                                end else begin
                                    par_err_s = 1'b1;
                                    drop_s    = 1'b1;
                                end
                            end else begin
                                drop_s = 1'b1;
                            end
                        end
                        OP_DATA: begin
                            // CP is judged when the payload arrives so framing stays intact.
                            if (srcid_s == SRC_LTSM) begin
                                pend_hdr_s = i_deser_data;
                                timer_s    = 8'd0;
                                state_s    = ST_WAIT;
                            end else begin
                                drop_s = 1'b1;
                            end
                        end
                        default: begin
                            drop_s = 1'b1;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (timer_r >= TMO_LIMIT) begin
                    tmo_err_s = 1'b1;
                    drop_s    = 1'b1;
                    timer_s   = 8'd0;
                    state_s   = ST_IDLE;
                end else if (i_deser_valid) begin
                    timer_s = 8'd0;
                    state_s = ST_IDLE;
                    if (cp_ok(pend_hdr_r) && dp_ok(pend_hdr_r[63], i_deser_data)) begin
                        emit_ltsm_s     = 1'b1;
                        emit_has_data_s = 1'b1;
                        emit_hdr_s      = pend_hdr_r;
                        emit_data_s     = i_deser_data;
                    end else begin
                        par_err_s = 1'b1;
                        drop_s    = 1'b1;
                    end
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
                timer_s = 8'd0;
            end
        endcase
    end

    // State, held message registers, pulses and saturating drop counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r         <= ST_IDLE;
            timer_r         <= 8'd0;
            pend_hdr_r      <= 64'h0;
            rdi_start_r     <= 1'b0;
            rdi_hdr_r       <= 64'h0;
            ltsm_start_r    <= 1'b0;
            ltsm_hdr_r      <= 64'h0;
            ltsm_data_r     <= 64'h0;
            ltsm_has_data_r <= 1'b0;
            par_err_r       <= 1'b0;
            tmo_err_r       <= 1'b0;
            drop_cnt_r      <= 8'd0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            pend_hdr_r   <= pend_hdr_s;
            rdi_start_r  <= emit_rdi_s;
            ltsm_start_r <= emit_ltsm_s;
            par_err_r    <= par_err_s;
            tmo_err_r    <= tmo_err_s;
            if (emit_rdi_s) begin
                rdi_hdr_r <= emit_hdr_s;
            end else begin
                rdi_hdr_r <= rdi_hdr_r;
            end
            if (emit_ltsm_s) begin
                ltsm_hdr_r      <= emit_hdr_s;
                ltsm_data_r     <= emit_data_s;
                ltsm_has_data_r <= emit_has_data_s;
            end else begin
                ltsm_hdr_r      <= ltsm_hdr_r;
                ltsm_data_r     <= ltsm_data_r;
                ltsm_has_data_r <= ltsm_has_data_r;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end
    end

    assign o_rdi_start_en  = rdi_start_r;
    assign o_rdi_header    = rdi_hdr_r;
    assign o_ltsm_start_en = ltsm_start_r;
    assign o_ltsm_header   = ltsm_hdr_r;
    assign o_ltsm_data     = ltsm_data_r;
    assign o_ltsm_has_data = ltsm_has_data_r;
    assign o_parity_err    = par_err_r;
    assign o_timeout_err   = tmo_err_r;
    assign o_drop_cnt      = drop_cnt_r;

endmodule

// File: tb/tb_sb_rx_header_router.sv
// Directed self-checking bench for sb_rx_header_router (TIMEOUT_CYC = 4).
module tb_sb_rx_header_router;

    logic        i_clk;
    logic        i_rst;
    logic [63:0] i_deser_data;
    logic        i_deser_valid;
    logic        o_rdi_start_en;
    logic [63:0] o_rdi_header;
    logic        o_ltsm_start_en;
    logic [63:0] o_ltsm_header;
    logic [63:0] o_ltsm_data;
    logic        o_ltsm_has_data;
    logic        o_parity_err;
    logic        o_timeout_err;
    logic [7:0]  o_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sb_rx_header_router #(.TIMEOUT_CYC(4)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_deser_data(i_deser_data),
        .i_deser_valid(i_deser_valid),
        .o_rdi_start_en(o_rdi_start_en),
        .o_rdi_header(o_rdi_header),
        .o_ltsm_start_en(o_ltsm_start_en),
        .o_ltsm_header(o_ltsm_header),
        .o_ltsm_data(o_ltsm_data),
        .o_ltsm_has_data(o_ltsm_has_data),
        .o_parity_err(o_parity_err),
        .o_timeout_err(o_timeout_err),
        .o_drop_cnt(o_drop_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Header builder with correct even CP over [61:0].
    function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [2:0] src,
                                           input logic [7:0] mc, input logic [7:0] sc,
                                           input logic [2:0] dst, input logic dp);
        logic [63:0] h;
        h = 64'h0;
        h[4:0]   = op;
        h[31:29] = src;
        h[21:14] = mc;
        h[39:32] = sc;
        h[58:56] = dst;
        h[63]    = dp;
        h[62]    = ^h[61:0];
        return h;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w);
        i_deser_data  = w;
        i_deser_valid = 1'b1;
        tick();
        i_deser_valid = 1'b0;
        i_deser_data  = 64'h0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({o_rdi_start_en, o_ltsm_start_en, o_ltsm_has_data, o_parity_err, o_timeout_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 00000",
                {o_rdi_start_en, o_ltsm_start_en, o_ltsm_has_data, o_parity_err, o_timeout_err});
        end
        n_tests++;
        if ((o_rdi_header | o_ltsm_header | o_ltsm_data) !== 64'h0 || o_drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL reset_regs: got rdi=%h ltsm=%h data=%h drop=%0d want all 0",
                o_rdi_header, o_ltsm_header, o_ltsm_data, o_drop_cnt);
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_rdi_nodata();
        logic [63:0] h;
        h = mk_hdr(5'b10010, 3'b001, 8'h01, 8'h03, 3'b100, 1'b0);
        send(h);
        n_tests++;
        if (o_rdi_start_en !== 1'b1 || o_ltsm_start_en !== 1'b0) begin
            n_fail++; $display("FAIL rdi_start: got rdi=%b ltsm=%b want 1 0", o_rdi_start_en, o_ltsm_start_en);
        end
        n_tests++;
        if (o_rdi_header !== h) begin
            n_fail++; $display("FAIL rdi_header: got %h want %h", o_rdi_header, h);
        end
        tick();
        n_tests++;
        if (o_rdi_start_en !== 1'b0 || o_rdi_header !== h) begin
            n_fail++; $display("FAIL rdi_hold: got start=%b hdr=%h want 0 %h", o_rdi_start_en, o_rdi_header, h);
        end
    endtask

    task automatic test_ltsm_nodata();
        logic [63:0] h;
        h = mk_hdr(5'b10010, 3'b010, 8'h5A, 8'hC3, 3'b001, 1'b0);
        send(h);
        n_tests++;
        if (o_ltsm_start_en !== 1'b1 || o_ltsm_has_data !== 1'b0 || o_ltsm_data !== 64'h0 || o_ltsm_header !== h) begin
            n_fail++; $display("FAIL ltsm_nodata: got start=%b has=%b data=%h hdr=%h want 1 0 0 %h",
                o_ltsm_start_en, o_ltsm_has_data, o_ltsm_data, o_ltsm_header, h);
        end
        tick();
    endtask

    task automatic test_ltsm_data();
        logic [63:0] p;
        logic [63:0] h;
        p = 64'hDEADBEEF_0BADF00D;
        h = mk_hdr(5'b11011, 3'b010, 8'hAA, 8'h10, 3'b010, ^p);
        send(h);
        n_tests++;
        if (o_ltsm_start_en !== 1'b0) begin
            n_fail++; $display("FAIL ltsm_early: got %b want 0", o_ltsm_start_en);
        end
        tick();
        tick();
        send(p);
        n_tests++;
        if (o_ltsm_start_en !== 1'b1 || o_ltsm_has_data !== 1'b1) begin
            n_fail++; $display("FAIL ltsm_data_start: got start=%b has=%b want 1 1", o_ltsm_start_en, o_ltsm_has_data);
        end
        n_tests++;
        if (o_ltsm_data !== p || o_ltsm_header !== h) begin
            n_fail++; $display("FAIL ltsm_data_val: got data=%h hdr=%h want %h %h", o_ltsm_data, o_ltsm_header, p, h);
        end
        tick();
        n_tests++;
        if (o_ltsm_start_en !== 1'b0 || o_drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL ltsm_after: got start=%b drop=%0d want 0 0", o_ltsm_start_en, o_drop_cnt);
        end
    endtask

    task automatic test_cp_err();
        logic [63:0] h;
        logic [63:0] prev;
        prev = o_rdi_header;
        h = mk_hdr(5'b10010, 3'b001, 8'h22, 8'h07, 3'b000, 1'b0);
        h[62] = ~h[62];
        send(h);
        n_tests++;
        if (o_parity_err !== 1'b1 || o_drop_cnt !== 8'd1 || o_rdi_start_en !== 1'b0) begin
            n_fail++; $display("FAIL cp_err: got perr=%b drop=%0d start=%b want 1 1 0",
                o_parity_err, o_drop_cnt, o_rdi_start_en);
        end
        n_tests++;
        if (o_rdi_header !== prev) begin
            n_fail++; $display("FAIL cp_err_hold: got %h want %h", o_rdi_header, prev);
        end
        tick();
        n_tests++;
        if (o_parity_err !== 1'b0) begin
            n_fail++; $display("FAIL cp_err_width: got %b want 0", o_parity_err);
        end
    endtask

    task automatic test_dp_err();
        logic [63:0] p;
        logic [63:0] h;
        p = 64'h0000_0000_0000_0007;
        h = mk_hdr(5'b11011, 3'b010, 8'h33, 8'h44, 3'b011, ~(^p));
        send(h);
        send(p);
        n_tests++;
        if (o_parity_err !== 1'b1 || o_ltsm_start_en !== 1'b0 || o_drop_cnt !== 8'd2) begin
            n_fail++; $display("FAIL dp_err: got perr=%b start=%b drop=%0d want 1 0 2",
                o_parity_err, o_ltsm_start_en, o_drop_cnt);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [63:0] h;
        logic [63:0] r;
        int tmo_cnt;
        int start_cnt;
        tmo_cnt   = 0;
        start_cnt = 0;
        h = mk_hdr(5'b11011, 3'b010, 8'h09, 8'h01, 3'b000, 1'b0);
        send(h);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_timeout_err === 1'b1) tmo_cnt++;
            if (o_ltsm_start_en === 1'b1) start_cnt++;
        end
        n_tests++;
        if (tmo_cnt !== 1 || start_cnt !== 0) begin
            n_fail++; $display("FAIL timeout_pulse: got tmo=%0d start=%0d want 1 0", tmo_cnt, start_cnt);
        end
        n_tests++;
        if (o_drop_cnt !== 8'd3) begin
            n_fail++; $display("FAIL timeout_drop: got %0d want 3", o_drop_cnt);
        end
        r = mk_hdr(5'b10010, 3'b001, 8'h77, 8'h88, 3'b111, 1'b0);
        send(r);
        n_tests++;
        if (o_rdi_start_en !== 1'b1 || o_rdi_header !== r) begin
            n_fail++; $display("FAIL timeout_resume: got start=%b hdr=%h want 1 %h", o_rdi_start_en, o_rdi_header, r);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] h;
        logic [63:0] p;
        a = mk_hdr(5'b10010, 3'b001, 8'hA1, 8'h01, 3'b001, 1'b0);
        b = mk_hdr(5'b10010, 3'b001, 8'hB2, 8'h02, 3'b010, 1'b0);
        p = 64'h1234_5678_9ABC_DEF0;
        h = mk_hdr(5'b11011, 3'b010, 8'hC3, 8'h03, 3'b011, ^p);
        i_deser_valid = 1'b1;
        i_deser_data  = a;
        tick();
        n_tests++;
        if (o_rdi_start_en !== 1'b1 || o_rdi_header !== a) begin
            n_fail++; $display("FAIL b2b_rdi1: got start=%b hdr=%h want 1 %h", o_rdi_start_en, o_rdi_header, a);
        end
        i_deser_data = b;
        tick();
        n_tests++;
        if (o_rdi_start_en !== 1'b1 || o_rdi_header !== b) begin
            n_fail++; $display("FAIL b2b_rdi2: got start=%b hdr=%h want 1 %h", o_rdi_start_en, o_rdi_header, b);
        end
        i_deser_data = h;
        tick();
        n_tests++;
        if (o_rdi_start_en !== 1'b0 || o_ltsm_start_en !== 1'b0) begin
            n_fail++; $display("FAIL b2b_hdr: got rdi=%b ltsm=%b want 0 0", o_rdi_start_en, o_ltsm_start_en);
        end
        i_deser_data = p;
        tick();
        i_deser_valid = 1'b0;
        n_tests++;
        if (o_ltsm_start_en !== 1'b1 || o_ltsm_data !== p || o_ltsm_header !== h || o_rdi_start_en !== 1'b0) begin
            n_fail++; $display("FAIL b2b_ltsm: got start=%b data=%h hdr=%h rdi=%b want 1 %h %h 0",
                o_ltsm_start_en, o_ltsm_data, o_ltsm_header, o_rdi_start_en, p, h);
        end
        n_tests++;
        if (o_drop_cnt !== 8'd3) begin
            n_fail++; $display("FAIL b2b_nodrop: got %0d want 3", o_drop_cnt);
        end
        tick();
    endtask

    task automatic test_saturation_reset();
        logic [63:0] h;
        logic [63:0] r;
        i_deser_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            i_deser_data = mk_hdr(5'b00001, 3'b001, 8'(i), 8'h00, 3'b000, 1'b0);
            tick();
        end
        i_deser_valid = 1'b0;
        n_tests++;
        if (o_drop_cnt !== 8'd255) begin
            n_fail++; $display("FAIL drop_sat: got %0d want 255", o_drop_cnt);
        end
        h = mk_hdr(5'b11011, 3'b010, 8'h01, 8'h01, 3'b000, 1'b0);
        send(h);
        i_rst = 1'b1;
        tick();
        n_tests++;
        if ({o_rdi_start_en, o_ltsm_start_en, o_ltsm_has_data, o_parity_err, o_timeout_err} !== 5'b0 ||
            (o_rdi_header | o_ltsm_header | o_ltsm_data) !== 64'h0 || o_drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset: got drop=%0d rdi=%h ltsm=%h data=%h want all 0",
                o_drop_cnt, o_rdi_header, o_ltsm_header, o_ltsm_data);
        end
        i_rst = 1'b0;
        r = mk_hdr(5'b10010, 3'b001, 8'h5E, 8'hE5, 3'b101, 1'b0);
        send(r);
        n_tests++;
        if (o_rdi_start_en !== 1'b1 || o_rdi_header !== r || o_drop_cnt !== 8'd0) begin
            n_fail++; $display("FAIL post_reset: got start=%b hdr=%h drop=%0d want 1 %h 0",
                o_rdi_start_en, o_rdi_header, o_drop_cnt, r);
        end
        tick();
    endtask

    initial begin
        i_rst         = 1'b1;
        i_deser_data  = 64'h0;
        i_deser_valid = 1'b0;
        test_reset();
        test_rdi_nodata();
        test_ltsm_nodata();
        test_ltsm_data();
        test_cp_err();
        test_dp_err();
        test_timeout();
        test_back_to_back();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
